// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared NoC router types and width helpers.
package switch_allocator_pkg;
    typedef enum logic [2:0] {LOCAL = 3'd0, XPOS, XNEG, YPOS, YNEG, ZPOS, ZNEG} port_e;
    typedef logic [2:0] route_t;
    function automatic int vc_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cred_bits(input int d);
        return $clog2(d) + 1;
    endfunction
endpackage

// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request/credit inputs and pop/crossbar outputs of the switch allocator.
interface switch_allocator_if
    import switch_allocator_pkg::*;
#(
    parameter int PORTS            = 7,
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int DEPTH            = 4
);
    localparam int VB = vc_bits(VIRTUAL_CHANNELS);
    localparam int CB = cred_bits(DEPTH);
    logic [PORTS-1:0][VIRTUAL_CHANNELS-1:0]         req;
    logic [PORTS-1:0][VIRTUAL_CHANNELS-1:0][2:0]    req_route;
    logic [PORTS-1:0][VIRTUAL_CHANNELS-1:0][VB-1:0] req_vc;
    logic [PORTS-1:0]                               credit_ret;
    logic [PORTS-1:0][VB-1:0]                       credit_ret_vc;
    logic [PORTS-1:0]                               pop;
    logic [PORTS-1:0][VB-1:0]                       pop_lane;
    logic [PORTS-1:0]                               xbar_valid;
    logic [PORTS-1:0][2:0]                          xbar_sel;
    logic [PORTS-1:0][VB-1:0]                       xbar_vc;
    logic [PORTS-1:0][VIRTUAL_CHANNELS-1:0][CB-1:0] credits;
    logic                                           credit_err;
`ifdef SWITCH_ALLOC_STATS_EN
    logic [PORTS-1:0][15:0]                         grant_count;
    modport master (output req, req_route, req_vc, credit_ret, credit_ret_vc,
                    input pop, pop_lane, xbar_valid, xbar_sel, xbar_vc, credits, credit_err, grant_count);
    modport slave  (input req, req_route, req_vc, credit_ret, credit_ret_vc,
                    output pop, pop_lane, xbar_valid, xbar_sel, xbar_vc, credits, credit_err, grant_count);
`else
    modport master (output req, req_route, req_vc, credit_ret, credit_ret_vc,
                    input pop, pop_lane, xbar_valid, xbar_sel, xbar_vc, credits, credit_err);
    modport slave  (input req, req_route, req_vc, credit_ret, credit_ret_vc,
                    output pop, pop_lane, xbar_valid, xbar_sel, xbar_vc, credits, credit_err);
`endif
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// switch_allocator_rr_arbiter: round-robin arbiter, pointer moves past the winner on upd.
module switch_allocator_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          upd,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    // Scan from the farthest offset down so the nearest requester to ptr is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr <= '0;
        else if (upd) ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first switch allocator with downstream credit tracking.
// Define SWITCH_ALLOC_STATS_EN to add per-output grant counters (grant_count).
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int PORTS            = 7,
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int DEPTH            = 4
) (
    input logic              clk,
    input logic              reset,
    switch_allocator_if.slave bus
);
    localparam int VB = vc_bits(VIRTUAL_CHANNELS);
    localparam int CB = cred_bits(DEPTH);
    localparam int PW = $clog2(PORTS);
    logic [CB-1:0]               cred  [PORTS][VIRTUAL_CHANNELS];
    logic [VIRTUAL_CHANNELS-1:0] elig  [PORTS];
    logic [VIRTUAL_CHANNELS-1:0] c_gnt [PORTS];
    logic [VIRTUAL_CHANNELS-1:0] dec   [PORTS];
    logic [VIRTUAL_CHANNELS-1:0] inc   [PORTS];
    logic [VB-1:0]               c_vc  [PORTS];
    logic [VB-1:0]               g_vc  [PORTS];
    route_t                      c_route [PORTS];
    logic [PORTS-1:0]            req2  [PORTS];
    logic [PORTS-1:0]            g2    [PORTS];
    logic [PW-1:0]               w     [PORTS];
    logic [PORTS-1:0]            won;
    logic [PORTS-1:0]            o_valid;
    // A VC competes only with a legal route and a credit on its downstream VC.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            elig[p] = '0;
            for (int v = 0; v < VIRTUAL_CHANNELS; v++)
                elig[p][v] = bus.req[p][v] && (bus.req_route[p][v] < route_t'(PORTS)) &&
                             (cred[bus.req_route[p][v]][bus.req_vc[p][v]] != '0);
        end
    end
    for (genvar p = 0; p < PORTS; p++) begin : g_in
        switch_allocator_rr_arbiter #(.N(VIRTUAL_CHANNELS), .IW(VB)) u_s1 (
            .clk(clk), .reset(reset), .req(elig[p]), .upd(won[p]), .gnt(c_gnt[p]), .idx(c_vc[p])
        );
        assign c_route[p] = bus.req_route[p][c_vc[p]];
    end
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            req2[o] = '0;
            for (int p = 0; p < PORTS; p++)
                req2[o][p] = (|c_gnt[p]) && (c_route[p] == route_t'(o));
        end
    end
    for (genvar o = 0; o < PORTS; o++) begin : g_out
        switch_allocator_rr_arbiter #(.N(PORTS), .IW(PW)) u_s2 (
            .clk(clk), .reset(reset), .req(req2[o]), .upd(|req2[o]), .gnt(g2[o]), .idx(w[o])
        );
    end
    always_comb begin
        won = '0;
        for (int o = 0; o < PORTS; o++) begin
            won        = won | g2[o];
            o_valid[o] = |req2[o];
            g_vc[o]    = bus.req_vc[w[o]][c_vc[w[o]]];
            dec[o]     = '0;
            inc[o]     = '0;
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                dec[o][v] = o_valid[o] && (g_vc[o] == VB'(v));
                inc[o][v] = bus.credit_ret[o] && (bus.credit_ret_vc[o] == VB'(v));
            end
        end
    end
    always_comb begin
        bus.credits = '0;
        for (int o = 0; o < PORTS; o++)
            for (int v = 0; v < VIRTUAL_CHANNELS; v++)
                bus.credits[o][v] = cred[o][v];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pop        <= '0;
            bus.pop_lane   <= '0;
            bus.xbar_valid <= '0;
            bus.xbar_sel   <= '0;
            bus.xbar_vc    <= '0;
            bus.credit_err <= 1'b0;
            for (int o = 0; o < PORTS; o++)
                for (int v = 0; v < VIRTUAL_CHANNELS; v++)
                    cred[o][v] <= CB'(DEPTH);
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                bus.pop[p]      <= won[p];
                bus.pop_lane[p] <= won[p] ? c_vc[p] : '0;
            end
            for (int o = 0; o < PORTS; o++) begin
                bus.xbar_valid[o] <= o_valid[o];
                bus.xbar_sel[o]   <= o_valid[o] ? route_t'(w[o]) : '0;
                bus.xbar_vc[o]    <= o_valid[o] ? g_vc[o] : '0;
                // Simultaneous grant and return cancel; a return to a full counter saturates.
                for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                    if (dec[o][v] && !inc[o][v]) cred[o][v] <= cred[o][v] - 1'b1;
                    else if (inc[o][v] && !dec[o][v]) begin
                        if (cred[o][v] == CB'(DEPTH)) bus.credit_err <= 1'b1;
                        else cred[o][v] <= cred[o][v] + 1'b1;
                    end
                end
            end
        end
    end
`ifdef SWITCH_ALLOC_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.grant_count <= '0;
        else
            for (int o = 0; o < PORTS; o++)
                if (bus.xbar_valid[o]) bus.grant_count[o] <= bus.grant_count[o] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed and random checks of switch_allocator against a behavioural model.
module tb_switch_allocator;
    import switch_allocator_pkg::*;
    localparam int P = 7;
    localparam int V = 2;
    localparam int D = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    switch_allocator_if #(.PORTS(P), .VIRTUAL_CHANNELS(V), .DEPTH(D)) bus ();
    switch_allocator #(.PORTS(P), .VIRTUAL_CHANNELS(V), .DEPTH(D)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int errs = 0;
    int mcred [P][V];
    int iptr [P];
    int optr [P];
    int cand [P];
    int win  [P];
    bit merr;
    logic [P-1:0]   e_pop, e_lane, e_xv, e_xvc;
    logic [3*P-1:0] e_xs;
    logic [63:0]    all4;
    int cnt;
    int seq [6] = '{1, 3, 5, 1, 3, 5};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            iptr[o] = 0;
            optr[o] = 0;
            for (int v = 0; v < V; v++) mcred[o][v] = D;
        end
        merr = 1'b0;
    endtask

    // Expected registered outputs for the coming edge, from current inputs and model state.
    task automatic compute();
        int r;
        int p;
        int v;
        e_pop = '0; e_lane = '0; e_xv = '0; e_xvc = '0; e_xs = '0;
        for (int i = 0; i < P; i++) begin cand[i] = -1; win[i] = -1; end
        if (reset) begin
            for (int q = 0; q < P; q++)
                for (int i = 0; i < V; i++) begin
                    v = (iptr[q] + i) % V;
                    r = int'(bus.req_route[q][v]);
                    if (cand[q] < 0 && bus.req[q][v] && r < P && mcred[r][bus.req_vc[q][v]] > 0) cand[q] = v;
                end
            for (int o = 0; o < P; o++) begin
                for (int i = 0; i < P; i++) begin
                    p = (optr[o] + i) % P;
                    if (win[o] < 0 && cand[p] >= 0 && int'(bus.req_route[p][cand[p]]) == o) win[o] = p;
                end
                if (win[o] >= 0) begin
                    e_xv[o] = 1'b1;
                    e_xs[o*3 +: 3] = 3'(win[o]);
                    e_xvc[o] = bus.req_vc[win[o]][cand[win[o]]];
                    e_pop[win[o]] = 1'b1;
                    e_lane[win[o]] = 1'(cand[win[o]]);
                end
            end
        end
    endtask

    task automatic commit();
        bit g;
        bit rt;
        if (!reset) model_reset();
        else begin
            for (int o = 0; o < P; o++) begin
                for (int v = 0; v < V; v++) begin
                    g  = e_xv[o] && (int'(e_xvc[o]) == v);
                    rt = bus.credit_ret[o] && (int'(bus.credit_ret_vc[o]) == v);
                    if (g && !rt) mcred[o][v]--;
                    else if (rt && !g) begin
                        if (mcred[o][v] == D) merr = 1'b1;
                        else mcred[o][v]++;
                    end
                end
                if (win[o] >= 0) begin
                    optr[o] = (win[o] + 1) % P;
                    iptr[win[o]] = (cand[win[o]] + 1) % V;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [63:0] lane, xs, xvc, cr;
        lane = '0; xs = '0; xvc = '0; cr = '0;
        for (int o = 0; o < P; o++) begin
            lane[o] = bus.pop[o] ? bus.pop_lane[o][0] : 1'b0;
            xs[o*3 +: 3] = bus.xbar_valid[o] ? bus.xbar_sel[o] : 3'd0;
            xvc[o] = bus.xbar_valid[o] ? bus.xbar_vc[o][0] : 1'b0;
            for (int v = 0; v < V; v++) cr[(o*V+v)*3 +: 3] = 3'(mcred[o][v]);
        end
        chk("pop", 64'(bus.pop), 64'(e_pop));
        chk("pop_lane", lane, 64'(e_lane));
        chk("xbar_valid", 64'(bus.xbar_valid), 64'(e_xv));
        chk("xbar_sel", xs, 64'(e_xs));
        chk("xbar_vc", xvc, 64'(e_xvc));
        chk("credits", 64'(bus.credits), cr);
        chk("credit_err", 64'(bus.credit_err), 64'(merr));
    endtask

    task automatic step();
        compute();
        @(posedge clk);
        #1;
        commit();
        check_all();
    endtask

    task automatic clear();
        bus.req = '0; bus.req_route = '0; bus.req_vc = '0;
        bus.credit_ret = '0; bus.credit_ret_vc = '0;
    endtask

    initial begin
        clear();
        model_reset();
        all4 = '0;
        for (int i = 0; i < P * V; i++) all4[i*3 +: 3] = 3'd4;
        // Reset held: everything idle, full credits
        repeat (3) step();
        chk("reset_credits", 64'(bus.credits), all4);
        chk("reset_outputs", 64'({bus.pop, bus.xbar_valid, bus.credit_err}), 64'd0);
        reset = 1'b1;
        cnt = 0;
        repeat (10) begin step(); cnt += $countones(bus.pop); end
        chk("idle_pops", 64'(cnt), 64'd0);
        // Single grant 0 -> 2 on lane 1
        bus.req[0][1] = 1'b1; bus.req_route[0][1] = 3'd2; bus.req_vc[0][1] = 1'b0;
        step();
        chk("t2_pop0", 64'(bus.pop[0]), 64'd1);
        chk("t2_lane0", 64'(bus.pop_lane[0]), 64'd1);
        chk("t2_xv2", 64'(bus.xbar_valid[2]), 64'd1);
        chk("t2_sel2", 64'(bus.xbar_sel[2]), 64'd0);
        chk("t2_vc2", 64'(bus.xbar_vc[2]), 64'd0);
        chk("t2_cred20", 64'(bus.credits[2][0]), 64'd3);
        clear(); step();
        // Three inputs contend for output 4 with continuous returns
        for (int p = 1; p < 6; p += 2) begin
            bus.req[p][0] = 1'b1; bus.req_route[p][0] = 3'd4; bus.req_vc[p][0] = 1'b0;
        end
        bus.credit_ret[4] = 1'b1; bus.credit_ret_vc[4] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_sel4", 64'({bus.xbar_valid[4], bus.xbar_sel[4]}), 64'({1'b1, 3'(seq[k])}));
        end
        chk("t3_cred40", 64'(bus.credits[4][0]), 64'd4);
        clear(); step();
        // Credit exhaustion on (1,0), then a single return
        bus.req[0][0] = 1'b1; bus.req_route[0][0] = 3'd1; bus.req_vc[0][0] = 1'b0;
        cnt = 0;
        repeat (8) begin step(); cnt += int'(bus.pop[0]); end
        chk("t4_grants", 64'(cnt), 64'd4);
        chk("t4_cred10", 64'(bus.credits[1][0]), 64'd0);
        bus.credit_ret[1] = 1'b1; bus.credit_ret_vc[1] = 1'b0;
        step();
        bus.credit_ret = '0;
        chk("t4_ret_nogrant", 64'(bus.pop[0]), 64'd0);
        cnt = 0;
        repeat (5) begin step(); cnt += int'(bus.pop[0]); end
        chk("t4_regrant", 64'(cnt), 64'd1);
        clear(); step();
        // Grant and return on the same (6,1), then overflow return
        bus.req[2][1] = 1'b1; bus.req_route[2][1] = 3'd6; bus.req_vc[2][1] = 1'b1;
        bus.credit_ret[6] = 1'b1; bus.credit_ret_vc[6] = 1'b1;
        step();
        chk("t5_xv6", 64'(bus.xbar_valid[6]), 64'd1);
        chk("t5_cred61", 64'(bus.credits[6][1]), 64'd4);
        chk("t5_err0", 64'(bus.credit_err), 64'd0);
        bus.req = '0;
        step();
        chk("t5_sat", 64'(bus.credits[6][1]), 64'd4);
        chk("t5_err1", 64'(bus.credit_err), 64'd1);
        clear();
        repeat (3) step();
        chk("t5_sticky", 64'(bus.credit_err), 64'd1);
        // Mid-operation asynchronous reset
        for (int p = 2; p < 5; p += 2) begin
            bus.req[p][0] = 1'b1; bus.req_route[p][0] = 3'd3; bus.req_vc[p][0] = 1'b0;
        end
        bus.credit_ret[3] = 1'b1; bus.credit_ret_vc[3] = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("t6_pop", 64'(bus.pop), 64'd0);
        chk("t6_xv", 64'(bus.xbar_valid), 64'd0);
        chk("t6_credits", 64'(bus.credits), all4);
        chk("t6_err", 64'(bus.credit_err), 64'd0);
        model_reset();
        step();
        reset = 1'b1;
        step();
        chk("t6_first", 64'({bus.xbar_valid[3], bus.xbar_sel[3], bus.pop[2]}), 64'({1'b1, 3'd2, 1'b1}));
        // Random traffic, including illegal routes and spurious returns
        clear();
        repeat (400) begin
            for (int p = 0; p < P; p++) begin
                for (int v = 0; v < V; v++) begin
                    bus.req[p][v] = 1'($urandom_range(0, 1));
                    bus.req_route[p][v] = 3'($urandom_range(0, 7));
                    bus.req_vc[p][v] = 1'($urandom_range(0, 1));
                end
                bus.credit_ret[p] = ($urandom_range(0, 3) == 0);
                bus.credit_ret_vc[p] = 1'($urandom_range(0, 1));
            end
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
